// File: rtl/div_pkg.sv
// Shared opcodes, FSM state encoding and constants for the iterative divider.
package div_pkg;

    localparam logic [2:0] DIV_OP_DIV  = 3'b100;
    localparam logic [2:0] DIV_OP_DIVU = 3'b101;
    localparam logic [2:0] DIV_OP_REM  = 3'b110;
    localparam logic [2:0] DIV_OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SPEC = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Most negative two's-complement value of a w-bit word (caller truncates to w bits).
    function automatic logic [63:0] div_min_val(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_unit_param_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_unit_param_if #(
    parameter int WIDTH = 32
) ();
    // A request is taken on a rising edge where start=1, in_ready=1, div_op[2]=1 and flush=0;
    // otherwise start is dropped. done pulses for exactly one cycle with result valid.
    logic             start;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [2:0]       div_op;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, dividend, divisor, div_op, flush,
        input  in_ready, busy, done, result
    );

    modport slave (
        input  start, dividend, divisor, div_op, flush,
        output in_ready, busy, done, result
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {rem, quo} pair.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // The extra top bit keeps the shifted remainder exact for unsigned divisors near 2^WIDTH.
    always_comb begin
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_trial = w_shift - {1'b0, i_divisor};
        if (w_trial[WIDTH]) begin
            o_rem = w_shift[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end else begin
            o_rem = w_trial[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_unit_param.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU with fixed latency and flush.
module div_unit_param
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    div_unit_param_if.slave     bus,
    output div_state_e          o_dbg_state
);
    localparam int               CW      = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(div_min_val(WIDTH));

    div_state_e       r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_dvs_abs, r_spec_res, r_result;
    logic             r_neg_q, r_neg_r, r_want_rem, r_spec;

    logic             w_signed, w_a_neg, w_b_neg, w_div0, w_ovf, w_spec, w_accept, w_last;
    logic [WIDTH-1:0] w_a_abs, w_b_abs, w_spec_res, w_rem_n, w_quo_n, w_q_fix, w_r_fix;

    assign w_signed = ~bus.div_op[0];
    assign w_a_neg  = w_signed & bus.dividend[WIDTH-1];
    assign w_b_neg  = w_signed & bus.divisor[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -bus.dividend : bus.dividend;
    assign w_b_abs  = w_b_neg ? -bus.divisor  : bus.divisor;
    assign w_div0   = (bus.divisor == '0);
    assign w_ovf    = w_signed & (bus.dividend == MIN_VAL) & (bus.divisor == '1);
    assign w_spec   = w_div0 | w_ovf;
    assign w_accept = (r_state == ST_IDLE) & bus.start & bus.div_op[2] & ~bus.flush;
    assign w_last   = (r_cnt == LAST);

    // Divide-by-zero wins over overflow; both pick quotient or remainder by div_op[1].
    always_comb begin
        if (w_div0) w_spec_res = bus.div_op[1] ? bus.dividend : '1;
        else        w_spec_res = bus.div_op[1] ? '0 : MIN_VAL;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvs_abs),
        .o_rem     (w_rem_n),
        .o_quo     (w_quo_n)
    );

    assign w_q_fix = r_neg_q ? -w_quo_n : w_quo_n;
    assign w_r_fix = r_neg_r ? -w_rem_n : w_rem_n;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        bus.in_ready = (r_state == ST_IDLE);
        bus.busy     = (r_state != ST_IDLE);
        bus.done     = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: if (w_accept) w_next = (w_spec && EARLY_OUT) ? ST_SPEC : ST_CALC;
            ST_CALC: if (w_last) w_next = ST_DONE;
            ST_SPEC: w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (bus.flush) w_next = ST_IDLE;
    end

    // Datapath updates are suppressed under flush so an aborted operation never touches result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs_abs  <= '0;
            r_spec_res <= '0;
            r_result   <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_want_rem <= 1'b0;
            r_spec     <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_a_abs;
            r_dvs_abs  <= w_b_abs;
            r_spec_res <= w_spec_res;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_want_rem <= bus.div_op[1];
            r_spec     <= w_spec;
        end else if (r_state == ST_CALC && !bus.flush) begin
            r_cnt <= r_cnt + CW'(1);
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            if (w_last) r_result <= r_spec ? r_spec_res : (r_want_rem ? w_r_fix : w_q_fix);
        end else if (r_state == ST_SPEC && !bus.flush) begin
            r_result <= r_spec_res;
        end
    end

    assign bus.result  = r_result;
    assign o_dbg_state = r_state;
endmodule

// File: doc/div_unit_param.md
Name: div_unit_param

Overview:
- Parametrised iterative restoring divider for the execute stage.
- Implements RISC-V M-extension DIV/DIVU/REM/REMU at configurable WIDTH, with a start/busy/done handshake and pipeline flush.
- Adds what the current divider lacks:
  - correct divide-by-zero and signed-overflow results;
  - an optional early-out path;
  - a registered, stable result;
  - an exact, fixed latency.

Parameters:
- WIDTH, 32: operand/result width in bits; must be ≥4 and even.
- EARLY_OUT, 1: when 1, divide-by-zero and signed overflow complete in 1 cycle; when 0, they take the full latency.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when in_ready=1 and div_op[2]=1
- in_ready  out  1  high only in IDLE
- dividend  in  WIDTH  numerator; sampled on accept
- divisor  in  WIDTH  denominator; sampled on accept
- div_op  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU; sampled on accept
- flush  in  1  abort any in-flight operation
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse; result valid in that cycle
- result  out  WIDTH  registered; holds its value until the next done

Behaviour:
- States:
  - IDLE: on accept, latch operands, op, signs and absolute values, set counter=0, go to CALC. If special and EARLY_OUT=1, go to SPEC instead.
  - CALC: one restoring step per cycle on the {rem, quo} 2·WIDTH space:
    - shift left 1;
    - trial = rem_hi − |divisor| at WIDTH+1 bits;
    - trial negative → quo LSB 0, rem unchanged;
    - trial non-negative → rem = trial, quo LSB 1.
  - CALC runs for exactly WIDTH cycles. On the last step, apply sign correction, register result, go to DONE.
  - SPEC: register the special result, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: the accept edge is cycle 0.
  - Normal path: done high in cycle WIDTH+1.
  - EARLY_OUT special path: done high in cycle 2.
  - EARLY_OUT=0: special cases run CALC and the result is overridden at the end, so done is in cycle WIDTH+1.
- Sign rules (signed ops only):
  - quotient negative iff sign(dividend) XOR sign(divisor);
  - remainder takes the sign of the dividend;
  - quotient truncates toward zero.
- Unsigned ops ignore operand sign bits.
- Special cases:
  - divisor=0: quotient = all ones; remainder = dividend (unsigned ops too).
  - Signed overflow (dividend = MIN, divisor = −1, signed op): quotient = MIN; remainder = 0.
- Handshake:
  - start with busy=1 is ignored (no queueing, no error).
  - start with div_op[2]=0 is ignored.
  - in_ready = IDLE only. A new start is accepted no earlier than the cycle after done.
- flush:
  - Any state → IDLE at the next edge.
  - No done pulse; result keeps its previous value.
  - flush and start in the same IDLE cycle: start is not accepted.
- Priority: rst > flush > start.
- Reset values: state IDLE, busy 0, done 0, in_ready 1 (derived from state), result 0, counter 0.
  - Reset mid-operation discards the operation with no done pulse.
- Counter width: clog2(WIDTH)+1 bits. No wrap is reachable, because CALC exits on counter == WIDTH−1.

Decomposition:
- Package div_pkg:
  - funct3 localparams DIV_OP_DIV/DIVU/REM/REMU;
  - state encoding (IDLE, CALC, SPEC, DONE);
  - helper function for the WIDTH-bit MIN constant.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Parametrised by WIDTH; reusable for a future unrolled radix-4 variant.

Test Plan:
- WIDTH=32, DIV −7 / 2 → result 0xFFFFFFFD, done in cycle 33, busy high cycles 1–33. REM with the same operands → 0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF. REMU with the same operands → 0x0000000F.
- DIV 0x1234 / 0:
  - EARLY_OUT=1 → 0xFFFFFFFF with done in cycle 2;
  - REM with the same operands → 0x00001234;
  - EARLY_OUT=0 → same values with done in cycle 33.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Flush and ignored starts:
  - Start DIV 100/7; assert flush in cycle 10 → no done, busy=0 and in_ready=1 by cycle 11, result unchanged.
  - A start pulsed in cycle 5 is ignored.
  - Then DIVU 100/7 → 14.
- WIDTH=8, DIV 0x80 / 0x03 → 0xD6. REM with the same operands → 0xFE.
- rst asserted in cycle 12 → no done, result=0 next cycle.
